// File: rtl/clut_loader_pkg.sv
// Shared types and VRAM/CLUT geometry for the CLUT loader and its address generator.
package clut_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RECV,
        ST_DONE
    } state_e;

    localparam int VRAM_LINE_HW = 1024;
    localparam int VRAM_LINES   = 512;
    localparam int ADDR_W       = 18;

    // Burst length is tied to the 16-color palette granule.
    localparam int BURST_WORDS  = 8;
    localparam int BURSTS_8BPP  = 16;

    localparam int CLUT_X_LSB   = 0;
    localparam int CLUT_X_W     = 6;
    localparam int CLUT_Y_LSB   = 6;
    localparam int CLUT_Y_W     = 9;
    localparam int CLUT_ID_W    = CLUT_X_W + CLUT_Y_W;

    typedef struct packed {
        logic [CLUT_Y_W-1:0] y;
        logic [CLUT_X_W-1:0] x;
    } clut_id_t;

endpackage

// File: rtl/clut_loader_if.sv
// Front-end, VRAM arbiter and CLUT cache write signals of the loader; master is the loader.
interface clut_loader_if;
    import clut_loader_pkg::*;

    logic                 i_needLoading;
    logic [CLUT_ID_W-1:0] i_clutID;
    logic                 i_is8bpp;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_memReq;
    logic [ADDR_W-1:0]    o_memAddr;
    logic                 i_memAck;
    logic                 i_memDataValid;
    logic [31:0]          i_memData;
    logic                 o_write;
    logic [6:0]           o_writeIdx128;
    logic [31:0]          o_colorOut;

    modport master (
        input  i_needLoading, i_clutID, i_is8bpp, i_memAck, i_memDataValid, i_memData,
        output o_busy, o_done, o_memReq, o_memAddr, o_write, o_writeIdx128, o_colorOut
    );

    modport slave (
        output i_needLoading, i_clutID, i_is8bpp, i_memAck, i_memDataValid, i_memData,
        input  o_busy, o_done, o_memReq, o_memAddr, o_write, o_writeIdx128, o_colorOut
    );

endinterface

// File: rtl/clut_loader_addr_gen.sv
// Burst start word address: 16-halfword blocks advance along the CLUT's line and
// wrap at the 1024-halfword line end without touching Y.
module clut_loader_addr_gen
    import clut_loader_pkg::*;
(
    input  clut_id_t          clut_id_i,
    input  logic [3:0]        burst_i,
    output logic [ADDR_W-1:0] addr_o
);
    logic [CLUT_X_W-1:0] x_blk;

    // A block is 8 words, so the 6-bit block number wraps exactly at the line end.
    always_comb begin
        x_blk  = clut_id_i.x + {2'b00, burst_i};
        addr_o = {clut_id_i.y, x_blk, 3'b000};
    end

endmodule

// File: rtl/clut_loader.sv
// CLUT cache loader: on a miss, fetches 1 (4bpp) or 16 (8bpp) VRAM bursts and
// streams each 32-bit beat into the cache write port one cycle after it arrives.
module clut_loader
    import clut_loader_pkg::*;
(
    input  logic          clk,
    input  logic          i_rst,
    clut_loader_if.master bus
);
    state_e      state_q, state_d;
    clut_id_t    id_q;
    logic        is8bpp_q;
    logic [3:0]  burst_q;
    logic [3:0]  beat_q;
    logic [6:0]  widx_q;
    logic        wr_q;
    logic [6:0]  wr_idx_q;
    logic [31:0] color_q;
    logic        burst_full;
    logic        last_burst;
    logic        beat_take;

    assign burst_full = (beat_q == 4'(BURST_WORDS));
    assign last_burst = !is8bpp_q || (burst_q == 4'(BURSTS_8BPP - 1));
    assign beat_take  = (state_q == ST_RECV) && bus.i_memDataValid && !burst_full;

    clut_loader_addr_gen u_addr_gen (
        .clut_id_i (id_q),
        .burst_i   (burst_q),
        .addr_o    (bus.o_memAddr)
    );

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // RECV lingers one cycle after the last beat so o_done trails the final write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.i_needLoading) state_d = ST_REQ;
            ST_REQ:  if (bus.i_memAck)      state_d = ST_RECV;
            ST_RECV: if (burst_full)        state_d = last_burst ? ST_DONE : ST_REQ;
            ST_DONE:                        state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_busy        = (state_q != ST_IDLE);
        bus.o_done        = (state_q == ST_DONE);
        bus.o_memReq      = (state_q == ST_REQ);
        bus.o_write       = wr_q;
        bus.o_writeIdx128 = wr_idx_q;
        bus.o_colorOut    = color_q;
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            id_q     <= '0;
            is8bpp_q <= 1'b0;
            burst_q  <= '0;
            beat_q   <= '0;
            widx_q   <= '0;
            wr_q     <= 1'b0;
            wr_idx_q <= '0;
            color_q  <= '0;
        end else begin
            wr_q <= beat_take;
            if (beat_take) begin
                color_q  <= bus.i_memData;
                wr_idx_q <= widx_q;
                widx_q   <= widx_q + 7'd1;
                beat_q   <= beat_q + 4'd1;
            end
            case (state_q)
                ST_IDLE: if (bus.i_needLoading) begin
                    id_q     <= clut_id_t'(bus.i_clutID);
                    is8bpp_q <= bus.i_is8bpp;
                    burst_q  <= '0;
                    widx_q   <= '0;
                end
                ST_REQ:  if (bus.i_memAck) beat_q <= '0;
                ST_RECV: if (burst_full && !last_burst) burst_q <= burst_q + 4'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clut_loader.sv
// Randomized bench for clut_loader: a VRAM responder with random ack delay and beat
// gaps, checked against palette geometry computed directly from X/Y/bpp.
module tb_clut_loader;
    import clut_loader_pkg::*;

    logic clk = 1'b0;
    logic i_rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clut_loader_if bus();
    clut_loader dut (.clk(clk), .i_rst(i_rst), .bus(bus));

    int          wr_idx_q[$];
    logic [31:0] wr_dat_q[$];
    int          wr_cyc_q[$];
    int          done_cyc_q[$];

    always @(negedge clk) begin
        if (bus.o_write === 1'b1) begin
            wr_idx_q.push_back(int'(bus.o_writeIdx128));
            wr_dat_q.push_back(bus.o_colorOut);
            wr_cyc_q.push_back(cyc);
        end
        if (bus.o_done === 1'b1) done_cyc_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int exp_addr(input int x, input int y, input int k);
        return y * (VRAM_LINE_HW / 2) + (((x * 16 + k * 16) % VRAM_LINE_HW) / 2);
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  bus.o_busy, 0);
        chk({tag, "_done"},  bus.o_done, 0);
        chk({tag, "_req"},   bus.o_memReq, 0);
        chk({tag, "_addr"},  bus.o_memAddr, 0);
        chk({tag, "_wr"},    bus.o_write, 0);
        chk({tag, "_idx"},   bus.o_writeIdx128, 0);
        chk({tag, "_color"}, bus.o_colorOut, 0);
    endtask

    task automatic clear_mon();
        wr_idx_q.delete(); wr_dat_q.delete(); wr_cyc_q.delete(); done_cyc_q.delete();
    endtask

    task automatic send_beat(output logic [31:0] d, output int c);
        d = $urandom;
        c = cyc;
        bus.i_memData      = d;
        bus.i_memDataValid = 1'b1;
        step();
        bus.i_memDataValid = 1'b0;
        bus.i_memData      = $urandom;
    endtask

    task automatic start_load(input int x, input int y, input bit is8);
        bus.i_clutID      = 15'(y * 64 + x);
        bus.i_is8bpp      = is8;
        bus.i_needLoading = 1'b1;
        step();
        bus.i_needLoading = 1'b0;
        bus.i_clutID      = 15'($urandom);
        bus.i_is8bpp      = 1'($urandom);
    endtask

    task automatic do_load(input int x, input int y, input bit is8, input int gmin, input int gmax,
                           input int ack_dly, input bit poke, input bit pulse_at_done);
        int          nb = is8 ? BURSTS_8BPP : 1;
        logic [31:0] exp_dat[$];
        int          beat_cyc[$];
        logic [31:0] d;
        int          c;
        int          t;
        int          last;
        clear_mon();
        start_load(x, y, is8);
        chk("busy_start", bus.o_busy, 1);
        for (int k = 0; k < nb; k++) begin
            t = 0;
            while (bus.o_memReq !== 1'b1 && t < 50) begin step(); t++; end
            chk("req_seen", bus.o_memReq, 1);
            chk("req_addr", bus.o_memAddr, exp_addr(x, y, k));
            for (int w = 0; w < ack_dly; w++) begin
                step();
                chk("req_hold", bus.o_memReq, 1);
                chk("addr_hold", bus.o_memAddr, exp_addr(x, y, k));
            end
            bus.i_memAck = 1'b1;
            step();
            bus.i_memAck = 1'b0;
            chk("req_drop", bus.o_memReq, 0);
            for (int b = 0; b < BURST_WORDS; b++) begin
                int gap = $urandom_range(gmax, gmin);
                if (poke && k == 2 && b == 3) begin
                    bus.i_clutID      = 15'(((y + 7) % 512) * 64 + ((x + 13) % 64));
                    bus.i_is8bpp      = 1'b0;
                    bus.i_needLoading = 1'b1;
                    step();
                    bus.i_needLoading = 1'b0;
                end
                repeat (gap) step();
                send_beat(d, c);
                exp_dat.push_back(d);
                beat_cyc.push_back(c);
            end
        end
        t = 0;
        while (bus.o_done !== 1'b1 && t < 50) begin step(); t++; end
        chk("done_seen", bus.o_done, 1);
        if (pulse_at_done) begin
            bus.i_clutID      = 15'(((y + 3) % 512) * 64 + ((x + 5) % 64));
            bus.i_is8bpp      = 1'b0;
            bus.i_needLoading = 1'b1;
        end
        step();
        chk("busy_after_done", bus.o_busy, 0);
        chk("done_one_cycle", bus.o_done, 0);
        if (pulse_at_done) begin
            step();
            bus.i_needLoading = 1'b0;
            chk("accept_after_done_busy", bus.o_busy, 1);
            chk("accept_after_done_req", bus.o_memReq, 1);
            chk("accept_after_done_addr", bus.o_memAddr, exp_addr((x + 5) % 64, (y + 3) % 512, 0));
            i_rst = 1'b1;
            step();
            i_rst = 1'b0;
        end
        chk("n_writes", wr_idx_q.size(), nb * BURST_WORDS);
        for (int i = 0; i < nb * BURST_WORDS && i < wr_idx_q.size(); i++) begin
            chk("wr_idx", wr_idx_q[i], i);
            chk("wr_data", wr_dat_q[i], exp_dat[i]);
            chk("wr_latency", wr_cyc_q[i], beat_cyc[i] + 1);
        end
        chk("n_done", done_cyc_q.size(), 1);
        last = wr_cyc_q.size() - 1;
        if (done_cyc_q.size() > 0 && last >= 0)
            chk("done_align", done_cyc_q[0], wr_cyc_q[last] + 1);
        step();
    endtask

    initial begin
        logic [31:0] d;
        int          c;
        int          t;
        i_rst              = 1'b1;
        bus.i_needLoading  = 1'b0;
        bus.i_clutID       = '0;
        bus.i_is8bpp       = 1'b0;
        bus.i_memAck       = 1'b0;
        bus.i_memDataValid = 1'b0;
        bus.i_memData      = '0;
        repeat (3) step();
        chk_reset_vals("rst");
        i_rst = 1'b0;
        step();

        // Stray handshake inputs while idle must not start anything.
        clear_mon();
        bus.i_memAck       = 1'b1;
        bus.i_memDataValid = 1'b1;
        bus.i_memData      = 32'hdead_beef;
        repeat (2) step();
        bus.i_memAck       = 1'b0;
        bus.i_memDataValid = 1'b0;
        step();
        chk("idle_busy", bus.o_busy, 0);
        chk("idle_req", bus.o_memReq, 0);
        chk("idle_writes", wr_idx_q.size(), 0);

        do_load(3, 10, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        do_load(0, 0, 1'b1, 0, 2, 1, 1'b0, 1'b0);
        do_load(60, 5, 1'b1, 0, 1, 2, 1'b0, 1'b0);
        do_load($urandom_range(63, 0), $urandom_range(511, 0), 1'b0, 1, 1, 5, 1'b0, 1'b0);
        do_load($urandom_range(63, 0), $urandom_range(511, 0), 1'b1, 0, 2, 1, 1'b1, 1'b0);
        do_load($urandom_range(63, 0), $urandom_range(511, 0), 1'b0, 0, 2, 0, 1'b0, 1'b1);

        // Abort mid-burst with an asynchronous reset, then reload from scratch.
        start_load(9, 33, 1'b0);
        t = 0;
        while (bus.o_memReq !== 1'b1 && t < 50) begin step(); t++; end
        chk("abort_req_seen", bus.o_memReq, 1);
        bus.i_memAck = 1'b1;
        step();
        bus.i_memAck = 1'b0;
        for (int b = 0; b < 3; b++) send_beat(d, c);
        #2 i_rst = 1'b1;
        #1 chk_reset_vals("async_rst");
        step();
        i_rst = 1'b0;
        step();
        do_load($urandom_range(63, 0), $urandom_range(511, 0), 1'b0, 0, 1, 1, 1'b0, 1'b0);

        for (int n = 0; n < 6; n++)
            do_load($urandom_range(63, 0), $urandom_range(511, 0), 1'($urandom),
                    0, $urandom_range(3, 0), $urandom_range(4, 0), 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
